serial_addsub: RTL and testbench

- Bit-serial two's-complement adder/subtractor built around the team's single-bit full-adder cell plus a carry flip-flop.
- Accepts a WIDTH-bit operand pair on a start handshake and processes one bit per clock, LSB first.
- Reports sum/difference, carry-out and signed overflow with a one-cycle done pulse.
- Serves as the area-minimal arithmetic unit for the multi-cycle datapath and as the sequential counterpart of the combinational adder chain.

---
 rtl/addsub_pkg.sv | 6 +
 rtl/fa.sv | 11 +
 rtl/serial_addsub.sv | 68 ++++++
 tb/tb_serial_addsub.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and opcode constants for the serial adder/subtractor
package addsub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/fa.sv
// fa: single-bit full-adder cell
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor, LSB first, one bit per clock
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] sa_q, sb_q, res_q;
  logic c_q, cout_q, ovf_q, s, c, load, last;
  fa u_fa (.a_i(sa_q[0]), .b_i(sb_q[0]), .cin_i(c_q), .s_o(s), .cout_o(c));
  assign load   = start && (state_q == IDLE || state_q == DONE);
  assign last   = cnt_q == CW'(WIDTH - 1);
  assign busy   = state_q == RUN;
  assign done   = state_q == DONE;
  assign result = res_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  // next state: accept start from IDLE or DONE, leave RUN after the MSB, unknown codes fall back to IDLE
  always_comb begin
    state_d = IDLE;
    state_d = load ? RUN : state_q == RUN ? (last ? DONE : RUN) : IDLE;
  end
  // state register, operand latch, bit-serial shift datapath and flag capture on the MSB edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sa_q  <= a;
        sb_q  <= b ^ {WIDTH{sub}};
        c_q   <= sub == OP_SUB;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        sa_q  <= sa_q >> 1;
        sb_q  <= sb_q >> 1;
        res_q <= {s, res_q[WIDTH-1:1]};
        c_q   <= c;
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          cout_q <= c;
          ovf_q  <= c ^ c_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench for the 8-bit and 4-bit serial adder/subtractor
module tb_serial_addsub;
  typedef struct packed {logic [7:0] r; logic c; logic v;} exp8_t;
  typedef struct packed {logic [3:0] r; logic c; logic v;} exp4_t;
  logic clk, rst_n;
  logic start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, res8;
  logic start4, sub4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, res4;
  exp8_t q8[$];
  exp4_t q4[$];
  int n_cmp = 0;
  int n_bad = 0;

  serial_addsub #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
  );
  serial_addsub #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4), .cout(cout4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done8) begin
      n_cmp++;
      if (q8.size() == 0) begin
        n_bad++;
        $display("FAIL sb8_unexpected_done got result=%h cout=%b ovf=%b with no pending op", res8, cout8, ovf8);
      end else begin
        exp8_t e;
        e = q8.pop_front();
        if ({res8, cout8, ovf8} !== e) begin
          n_bad++;
          $display("FAIL sb8 got result=%h cout=%b ovf=%b want result=%h cout=%b ovf=%b", res8, cout8, ovf8, e.r, e.c, e.v);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      n_cmp++;
      if (q4.size() == 0) begin
        n_bad++;
        $display("FAIL sb4_unexpected_done got result=%h cout=%b ovf=%b with no pending op", res4, cout4, ovf4);
      end else begin
        exp4_t e;
        e = q4.pop_front();
        if ({res4, cout4, ovf4} !== e) begin
          n_bad++;
          $display("FAIL sb4 got result=%h cout=%b ovf=%b want result=%h cout=%b ovf=%b", res4, cout4, ovf4, e.r, e.c, e.v);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_done8();
    for (int k = 0; k < 40 && !done8; k++) @(negedge clk);
    if (!done8) check("timeout_done8", 32'd0, 32'd1);
  endtask

  task automatic wait_done4();
    for (int k = 0; k < 20 && !done4; k++) @(negedge clk);
    if (!done4) check("timeout_done4", 32'd0, 32'd1);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [7:0] er, input logic ec, input logic ev);
    q8.push_back({er, ec, ev});
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();
    @(negedge clk);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    check("reset_idle_8", {27'd0, busy8, done8, res8 != 0, cout8, ovf8}, 32'd0);
    check("reset_idle_4", {27'd0, busy4, done4, res4 != 0, cout4, ovf4}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_mid_run", {27'd0, busy8, done8, res8 != 0, cout8, ovf8}, 32'd0);
    check("reset_result", {24'd0, res8}, 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      seen |= done8;
    end
    check("no_done_after_abort", {31'd0, seen}, 32'd0);

    q8.push_back({8'h80, 1'b0, 1'b1});
    a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("done_timing_E%0d", i), {31'd0, done8}, {31'd0, i == 8});
    end
    @(negedge clk);
    check("done_one_cycle", {30'd0, done8, busy8}, 32'd0);
    check("result_holds", {22'd0, res8, cout8, ovf8}, {22'd0, 8'h80, 1'b0, 1'b1});

    issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    issue8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    issue8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    q8.push_back({8'h30, 1'b0, 1'b0});
    a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 3) begin a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; end
    end
    check("busy_while_start_held", {31'd0, busy8}, 32'd1);
    start8 = 1'b0;
    wait_done8();
    @(negedge clk);

    q8.push_back({8'h4B, 1'b0, 1'b0});
    a8 = 8'h3C; b8 = 8'h0F; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();
    q8.push_back({8'h96, 1'b1, 1'b0});
    a8 = 8'hC8; b8 = 8'h32; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("start_in_done_no_gap", {31'd0, busy8}, 32'd1);
    wait_done8();
    @(negedge clk);

    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          logic [3:0] av, bv, r;
          logic c, v;
          av = 4'(x);
          bv = s[0] ? ~4'(y) : 4'(y);
          {c, r} = {1'b0, av} + {1'b0, bv} + {4'd0, s[0]};
          v = (av[3] == bv[3]) && (r[3] != av[3]);
          q4.push_back({r, c, v});
          a4 = 4'(x); b4 = 4'(y); sub4 = s[0]; start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          wait_done4();
          @(negedge clk);
        end

    repeat (3) @(negedge clk);
    check("sb8_drained", q8.size(), 32'd0);
    check("sb4_drained", q4.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
